// File: rtl/waveform_player_ctrl_if.sv
// Sample-memory read port and sample output stream of the waveform player.
// The master side belongs to the player; the slave side to memory plus consumer.
interface waveform_player_ctrl_if #(
  parameter int BITS    = 16,
  parameter int COLUMNS = 2,
  parameter int ADDR_W  = 16
) ();
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [BITS*COLUMNS-1:0]   mem_data;
  logic [BITS*COLUMNS-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output mem_rd, mem_addr, out_data, out_valid,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_data, out_valid,
    output mem_data, out_ready
  );
endinterface

// File: rtl/waveform_player_ctrl.sv
// Paced sample-memory player: fetches one sample per DIV clocks and presents it on a
// valid/ready stream. Define WFPLAY_LOOP_EN to add the loop port (wrap to address 0).
module waveform_player_ctrl #(
  parameter int BITS    = 16,
  parameter int COLUMNS = 2,
  parameter int ADDR_W  = 16,
  parameter int DIV     = 15625
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
`ifdef WFPLAY_LOOP_EN
  input  logic                 loop,
`endif
  input  logic [ADDR_W-1:0]    length,
  waveform_player_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 drop
);

  localparam int CNT_W = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WAIT
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [ADDR_W-1:0]         r_addr;
  logic [ADDR_W-1:0]         r_len;
  logic [CNT_W-1:0]          r_cnt;
  logic [BITS*COLUMNS-1:0]   r_prefetch;
  logic [BITS*COLUMNS-1:0]   r_out_data;
  logic                      r_out_valid;
  logic                      r_done;
  logic                      r_drop;

  logic                      w_loop;
  logic                      w_tick;
  logic                      w_last;
  logic                      w_take;
  logic                      w_start_ok;
  logic                      w_load;

`ifdef WFPLAY_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_tick     = (r_cnt == CNT_W'(DIV - 1));
  assign w_last     = (r_addr == r_len - 1'b1);
  assign w_take     = r_out_valid && bus.out_ready;
  assign w_start_ok = (r_state == S_IDLE) && start && !stop && (length != '0);
  // stop beats a coincident tick, so the pending sample is never presented
  assign w_load     = (r_state == S_WAIT) && w_tick && !stop;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_next_state = r_state;
    if (stop) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (w_start_ok) w_next_state = S_FETCH;
        S_FETCH:   w_next_state = S_CAPTURE;
        S_CAPTURE: w_next_state = S_WAIT;
        S_WAIT: begin
          if (w_tick) w_next_state = (w_last && !w_loop) ? S_IDLE : S_FETCH;
        end
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_rd    = (r_state == S_FETCH);
    bus.mem_addr  = r_addr;
    bus.out_data  = r_out_data;
    bus.out_valid = r_out_valid;
    busy          = (r_state != S_IDLE);
    done          = r_done;
    drop          = r_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_done <= w_load && w_last && !w_loop;
      r_drop <= w_load && r_out_valid && !bus.out_ready;

      if (w_start_ok) begin
        r_len  <= length;
        r_addr <= '0;
      end else if (w_load) begin
        if (!w_last)     r_addr <= r_addr + 1'b1;
        else if (w_loop) r_addr <= '0;
      end

      // Sample-period counter: free-runs while playing, parked at 0 otherwise
      if (w_start_ok || (r_state == S_IDLE) || stop || w_tick) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_out_data  <= r_prefetch;
        r_out_valid <= 1'b1;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the prefetch register is left out of reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) r_prefetch <= bus.mem_data;
  end

endmodule

// File: tb/tb_waveform_player_ctrl.sv
// Self-checking bench for waveform_player_ctrl: directed scenarios plus random
// start/stop/reset/backpressure traffic compared against an event-level model.
module tb_waveform_player_ctrl;

  localparam int BITS    = 16;
  localparam int COLUMNS = 2;
  localparam int ADDR_W  = 16;
  localparam int DIV     = 8;
  localparam int DW      = BITS * COLUMNS;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              loop_i;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic              drop;

  waveform_player_ctrl_if #(.BITS(BITS), .COLUMNS(COLUMNS), .ADDR_W(ADDR_W)) bus ();

  waveform_player_ctrl #(
    .BITS(BITS), .COLUMNS(COLUMNS), .ADDR_W(ADDR_W), .DIV(DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
`ifdef WFPLAY_LOOP_EN
    .loop   (loop_i),
`endif
    .length (length),
    .bus    (bus.master),
    .busy   (busy),
    .done   (done),
    .drop   (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int addr);
    return DW'(32'h10000 + addr);
  endfunction

  // Sample memory with one cycle of read latency
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= pat(int'(bus.mem_addr));

  int n_vec = 0;
  int n_err = 0;
  int n_done;
  int n_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: time since the accepted start decides ticks; samples are counted.
  bit          m_busy;
  int          m_t;
  int          m_idx;
  int          m_len;
  logic [DW-1:0] m_data;
  bit          m_valid;
  bit          m_done;
  bit          m_drop;

  function automatic bit loop_on();
`ifdef WFPLAY_LOOP_EN
    return loop_i;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update();
    bit take;
    if (rst) begin
      m_busy = 0; m_t = 0; m_idx = 0; m_len = 0;
      m_data = '0; m_valid = 0; m_done = 0; m_drop = 0;
    end else begin
      take   = m_valid && bus.out_ready;
      m_done = 0;
      m_drop = 0;
      if (stop) begin
        m_busy = 0;
        if (take) m_valid = 0;
      end else if (m_busy) begin
        if ((m_t + 1) % DIV == 0) begin
          m_drop  = m_valid && !bus.out_ready;
          m_data  = pat(m_idx);
          m_valid = 1;
          m_idx++;
          if (m_idx == m_len) begin
            if (loop_on()) m_idx = 0;
            else begin m_busy = 0; m_done = 1; end
          end
        end else if (take) begin
          m_valid = 0;
        end
        m_t++;
      end else begin
        if (take) m_valid = 0;
        if (start && length != 0) begin
          m_busy = 1; m_t = 0; m_idx = 0; m_len = int'(length);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check("busy",      64'(busy),          64'(m_busy));
    check("done",      64'(done),          64'(m_done));
    check("drop",      64'(drop),          64'(m_drop));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("out_data",  64'(bus.out_data),  64'(m_data));
    check("mem_rd",    64'(bus.mem_rd),    64'(m_busy && (m_t % DIV == 0)));
    if (m_busy) check("mem_addr", 64'(bus.mem_addr), 64'(m_idx));
    if (done) n_done++;
    if (drop) n_drop++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start(input int len);
    length = ADDR_W'(len);
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  int first_at;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_i = 1'b0; length = '0;
    bus.out_ready = 1'b1;
    run(2);
    rst = 1'b0;
    check("rst_addr",  64'(bus.mem_addr),  64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data",  64'(bus.out_data),  64'd0);
    run(2);

    // One-shot, consumer always ready
    n_done = 0; n_drop = 0; first_at = -1;
    pulse_start(4);
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (bus.out_valid && first_at < 0) first_at = i;
    end
    check("first_sample_cycle", 64'(first_at), 64'd8);
    check("oneshot_done_cnt",   64'(n_done),   64'd1);
    check("oneshot_drop_cnt",   64'(n_drop),   64'd0);
    check("oneshot_busy",       64'(busy),     64'd0);

    // One-shot, consumer stalled: later samples overwrite earlier ones
    bus.out_ready = 1'b0;
    n_done = 0; n_drop = 0;
    pulse_start(4);
    run(45);
    check("stall_drop_cnt", 64'(n_drop),        64'd3);
    check("stall_done_cnt", 64'(n_done),        64'd1);
    check("stall_data",     64'(bus.out_data),  64'h10003);
    check("stall_valid",    64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    run(2);

    // start together with stop, and zero-length start, are both ignored
    stop = 1'b1; pulse_start(4); stop = 1'b0;
    check("start_stop_busy", 64'(busy), 64'd0);
    pulse_start(0);
    check("zero_len_busy", 64'(busy), 64'd0);
    run(3);

    // Reset while fetching, then a clean replay
    pulse_start(3);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("midrst_busy",  64'(busy),          64'd0);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_addr",  64'(bus.mem_addr),  64'd0);
    n_done = 0;
    pulse_start(3);
    run(30);
    check("replay_done_cnt", 64'(n_done),       64'd1);
    check("replay_data",     64'(bus.out_data), 64'h10002);

    // start while busy does not restart or re-length playback
    n_done = 0;
    pulse_start(4);
    run(10);
    pulse_start(2);
    run(30);
    check("busy_start_done_cnt", 64'(n_done),       64'd1);
    check("busy_start_data",     64'(bus.out_data), 64'h10003);

`ifdef WFPLAY_LOOP_EN
    // Looping playback until aborted
    n_done = 0;
    loop_i = 1'b1;
    pulse_start(3);
    run(44);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("loop_stop_busy", 64'(busy),   64'd0);
    run(3);
    check("loop_done_cnt",  64'(n_done), 64'd0);
    loop_i = 1'b0;
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom % 8) == 0;
      stop          = ($urandom % 40) == 0;
      rst           = ($urandom % 300) == 0;
      length        = ADDR_W'($urandom % 6);
      bus.out_ready = ($urandom % 4) != 0;
      loop_i        = ($urandom % 3) == 0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/waveform_player_ctrl.md
WAVEFORM_PLAYER_CTRL -- requirements
Module: waveform_player_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 16, width of one sample column.
REQ-002 SHALL have parameter COLUMNS, default 2, columns per sample (I, Q).
REQ-003 SHALL have parameter ADDR_W, default 16, sample memory address width.
REQ-004 SHALL have parameter DIV, default 15625, clock cycles per sample period (100 MHz / 6400 S/s); legal range DIV >= 4.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle playback request.
REQ-008 SHALL have port stop, input, 1, single-cycle abort request.
REQ-009 SHALL have port loop, input, 1, wrap to address 0 after the last sample (only with WFPLAY_LOOP_EN).
REQ-010 SHALL have port length, input, ADDR_W, samples to play, sampled on an accepted start.
REQ-011 SHALL have port mem_rd, output, 1, sample memory read strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_W, sample memory address.
REQ-013 SHALL have port mem_data, input, BITS*COLUMNS, read data, valid exactly 1 cycle after mem_rd.
REQ-014 SHALL have port out_data, output, BITS*COLUMNS, current sample, column j at [BITS*j +: BITS].
REQ-015 SHALL have port out_valid, output, 1, out_data holds an unaccepted sample.
REQ-016 SHALL have port out_ready, input, 1, consumer accepts when out_valid and out_ready are both high.
REQ-017 SHALL have port busy, output, 1, playback in progress.
REQ-018 SHALL have port done, output, 1, single-cycle pulse at natural end of one-shot playback.
REQ-019 SHALL have port drop, output, 1, single-cycle pulse when an unaccepted sample is overwritten.

Function
REQ-020 SHALL implement states IDLE, FETCH (mem_rd high), CAPTURE (mem_data into prefetch register), WAIT_TICK.
REQ-021 IDLE: start with length != 0 and stop low SHALL latch length, set mem_addr=0, clear tick counter, set busy, enter FETCH; otherwise remain in IDLE.
REQ-022 start while busy SHALL be ignored; start with length == 0 SHALL be ignored.
REQ-023 FETCH SHALL assert mem_rd for exactly one cycle then enter CAPTURE; CAPTURE SHALL load the prefetch register and enter WAIT_TICK.
REQ-024 Tick counter SHALL count 0..DIV-1 while busy and wrap; tick = counter at DIV-1; first tick DIV cycles after the accepted start.
REQ-025 On tick in WAIT_TICK: out_data <= prefetch, out_valid <= 1, drop pulses next cycle if out_valid was high and not accepted in that cycle.
REQ-026 Same tick: mem_addr < length-1 SHALL increment mem_addr and enter FETCH.
REQ-027 Same tick: mem_addr == length-1 with loop low SHALL enter IDLE, clear busy, pulse done next cycle.
REQ-028 Same tick: mem_addr == length-1 with loop high SHALL set mem_addr=0 and enter FETCH.
REQ-029 A tick occurring outside WAIT_TICK cannot happen (DIV >= 4); not a supported condition.
REQ-030 Acceptance SHALL clear out_valid next cycle unless a tick loads a new sample in the same cycle (load wins, out_valid stays 1, no drop).
REQ-031 out_valid/out_data SHALL persist in IDLE until accepted.
REQ-032 stop SHALL have priority over start and tick: enter IDLE next cycle, busy=0, prefetch discarded, no done, out_valid/out_data unchanged.
REQ-033 mem_addr SHALL never exceed length-1 during playback.

Reset
REQ-034 rst SHALL force IDLE and out_data=0, out_valid=0, mem_rd=0, mem_addr=0, busy=0, done=0, drop=0, tick counter=0; rst overrides all inputs.
REQ-035 rst mid-playback SHALL abort with no done or drop pulse.

Configuration
REQ-036 Macro WFPLAY_LOOP_EN defined: loop port present, REQ-028 active.
REQ-037 Macro WFPLAY_LOOP_EN undefined: loop port absent, all playback one-shot per REQ-027.

Verification
REQ-038 DIV=8, length=4, mem_data=addr+0x10000, out_ready=1: samples 0x10000..0x10003 at cycles 8,16,24,32 after start; done 1 cycle after 4th; busy low.
REQ-039 Same, out_ready=0: drop pulses after ticks 2,3,4; final out_data=0x10003, out_valid=1 held in IDLE.
REQ-040 WFPLAY_LOOP_EN, loop=1, length=3: sequence 0,1,2,0,1,2 at 8-cycle spacing; no done; stop at cycle 45: busy=0 next cycle, no done.
REQ-041 start and stop same cycle in IDLE: remains IDLE, busy=0; start with length=0: busy stays 0.
REQ-042 rst asserted mid-FETCH: all outputs 0 next cycle; new start replays from address 0.
REQ-043 start pulsed while busy: ignored, sequence and timing unchanged.
